cla_pipe_adder: RTL and testbench
=================================

Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor; next generation of the team's 4-bit lookahead cell.
- Hierarchical lookahead over WIDTH bits in 4-bit groups; two register stages; valid/ready handshake on both sides.
- Sits between operand-issue logic and the result bus of the arithmetic datapath.
- Sustains one operation per clock when the downstream is ready.

Parameters:
- WIDTH, 64, operand/result width; must be a multiple of 4 and a power of two, range 8..128.
- GROUP, 4, lookahead group size; fixed at 4, the only supported value.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block accepts beat this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; ignored when sub=1
- sub  input  1  1: A - B (B inverted, carry-in forced 1)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB; for subtract, 1 means no borrow

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, sum=0, cout=0. All stage data registers clear to 0.
- Reset mid-operation discards every in-flight beat. No beat is emitted after release until a new accepted input.
- Stage 1 (register S1), loaded on in_valid && in_ready:
  - b_eff = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Per-bit p = a^b_eff, g = a&b_eff.
  - Per 4-bit group: group P = AND of p; group G = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Register p, g, group P/G and c0.
- Stage 2 (register S2 = output):
  - Second-level lookahead over group P/G produces the carry into each group.
  - Bits inside each group resolve from that carry: c[i+1] = g[i] | p[i]&c[i]. sum[i] = p[i]^c[i].
  - cout = carry out of bit WIDTH-1.
  - All carry logic is lookahead-only; no ripple across group boundaries.
- Handshake:
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv, combinational from out_ready and the valids; no combinational path from in_valid.
  - S2 loads from S1 when s2_adv; out_valid <= s1_valid.
  - S1 loads the input when s1_adv; s1_valid <= in_valid.
- Latency: exactly 2 cycles from acceptance to out_valid with out_ready held high. Throughput 1 beat/cycle.
- Backpressure: while out_valid && !out_ready, sum/cout/out_valid are held stable. S1 fills, then in_ready drops.
  - Both stages full + out_ready=0 => in_ready=0.
  - Both stages full + out_ready=1 in the same cycle as in_valid=1 => output retires, S1 shifts to S2, new beat enters S1 in one edge; no bubble, no loss.
- Ordering: strict FIFO. Maximum 2 beats in flight.
- Wrap-around: arithmetic is modulo 2^WIDTH; the carry is reported only via cout.
- in_valid may drop at any cycle; no beat is accepted while in_valid=0.

Optional Feature:
- Macro CLA_PIPE_FLAGS_EN.
- Defined: adds two output ports, each registered in S2 and aligned with sum, reset to 0:
  - zero (1): sum == 0.
  - ovf (1): signed overflow = carry into MSB XOR carry out of MSB.
- Not defined: neither port exists, no flag logic is synthesised, and all other behaviour is identical.

Test Plan:
- Reset/basic add, WIDTH=64: rst_n low, then a=0x0000_0000_FFFF_FFFF, b=1, cin=0, sub=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x0000_0001_0000_0000, cout=0.
- Full-carry propagate: a=all-ones, b=0, cin=1 -> sum=0, cout=1. With CLA_PIPE_FLAGS_EN: zero=1, ovf=0.
- Subtract: a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0. Then a=7, b=5, sub=1 -> sum=2, cout=1.
- Backpressure: stream 4 beats (a=i, b=i, i=1..4) with out_ready=0 for 3 cycles:
  - in_ready falls after 2 beats are accepted; out_valid held with sum=2 stable.
  - Raise out_ready -> outputs 2, 4, 6, 8 in order, one per cycle, no drops or duplicates.
- Async reset mid-stream: assert rst_n low between clock edges with 2 beats in flight -> out_valid=0 and sum=0 immediately. After release, no stale beat appears.
- Random regression: 10k beats, random a/b/cin/sub, random in_valid/out_ready -> every result matches the reference model a + (sub ? ~b : b) + (sub ? 1 : cin), in order. With CLA_PIPE_FLAGS_EN, also checks signed 0x7FFF..F + 1 -> ovf=1.

Source files
------------

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: two-stage pipelined carry-lookahead adder/subtractor.
// Operands are split into 4-bit groups. Stage 1 computes per-bit propagate
// and generate terms and the group P/G terms. Stage 2 runs a second-level
// lookahead over the groups, resolves the bits inside each group and
// registers the result. A valid/ready handshake is used on both sides, and
// the block holds at most two beats in flight.
// Optional build macro CLA_PIPE_FLAGS_EN adds the registered zero/ovf outputs.
module cla_pipe_adder #(
   parameter int WIDTH = 64,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CLA_PIPE_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);

   // Number of 4-bit lookahead groups across the operand width.
   localparam int NG = WIDTH / GROUP;

   // ---------------------------------------------------------------
   // Handshake / control
   // ---------------------------------------------------------------
   logic s2_adv;
   logic s1_adv;
   logic s1_load;
   logic s2_load;
   logic s1_valid_q, s1_valid_d;
   logic out_valid_q, out_valid_d;

   // ---------------------------------------------------------------
   // Stage 1: bit and group propagate/generate
   // ---------------------------------------------------------------
   logic [WIDTH-1:0]    b_eff;
   logic [WIDTH-1:0]    p_in;
   logic [WIDTH-1:0]    g_in;
   logic [NG-1:0]       gp_in;
   logic [NG-1:0]       gg_in;
   logic                c0_in;

   // The top generate bit of each group only feeds the group G term, so
   // only the lower three generate bits of each group are carried into S1.
   logic [WIDTH-1:0]    s1_p_q, s1_p_d;
   logic [NG-1:0][2:0]  s1_g_q, s1_g_d;
   logic [NG-1:0]       s1_gp_q, s1_gp_d;
   logic [NG-1:0]       s1_gg_q, s1_gg_d;
   logic                s1_c0_q, s1_c0_d;

   // ---------------------------------------------------------------
   // Stage 2: carry resolution and result registers
   // ---------------------------------------------------------------
   logic [NG:0]         gc;
   logic [WIDTH-1:0]    sum_res;
   logic                acc;
   logic                term;
   logic [3:0]          pv;
   logic [2:0]          gv;
   logic [3:0]          cv;

   logic [WIDTH-1:0]    sum_q, sum_d;
   logic                cout_q, cout_d;

`ifdef CLA_PIPE_FLAGS_EN
   logic                msb_cin;
   logic                zero_q, zero_d;
   logic                ovf_q, ovf_d;
`endif

   // Pipeline advance conditions; in_ready never depends on in_valid.
   always_comb begin
      s2_adv      = !out_valid_q || out_ready;
      s1_adv      = !s1_valid_q || s2_adv;
      in_ready    = s1_adv;
      s1_load     = in_valid && s1_adv;
      s2_load     = s1_valid_q && s2_adv;
      s1_valid_d  = s1_adv ? in_valid : s1_valid_q;
      out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
   end

   // Operand conditioning plus bit-level and group-level P/G terms.
   always_comb begin
      b_eff = sub ? ~b : b;
      c0_in = sub | cin;
      p_in  = a ^ b_eff;
      g_in  = a & b_eff;
      gp_in = '0;
      gg_in = '0;
      for (int j = 0; j < NG; j++) begin
         gp_in[j] = &p_in[4*j +: 4];
         gg_in[j] = g_in[4*j+3]
                  | (p_in[4*j+3] & g_in[4*j+2])
                  | (p_in[4*j+3] & p_in[4*j+2] & g_in[4*j+1])
                  | (p_in[4*j+3] & p_in[4*j+2] & p_in[4*j+1] & g_in[4*j]);
      end
   end

   // S1 next state: capture the new beat on acceptance, otherwise hold.
   always_comb begin
      s1_p_d  = s1_p_q;
      s1_g_d  = s1_g_q;
      s1_gp_d = s1_gp_q;
      s1_gg_d = s1_gg_q;
      s1_c0_d = s1_c0_q;
      if (s1_load) begin
         s1_p_d  = p_in;
         s1_gp_d = gp_in;
         s1_gg_d = gg_in;
         s1_c0_d = c0_in;
         for (int j = 0; j < NG; j++) begin
            s1_g_d[j] = g_in[4*j +: 3];
         end
      end
   end

   // Second-level lookahead: each group carry-in is a flat sum of products
   // of the group G/P terms and c0, then the bits resolve within each group.
   always_comb begin
      gc      = '0;
      sum_res = '0;
      acc     = 1'b0;
      term    = 1'b0;
      pv      = '0;
      gv      = '0;
      cv      = '0;
`ifdef CLA_PIPE_FLAGS_EN
      msb_cin = 1'b0;
`endif
      for (int j = 0; j <= NG; j++) begin
         acc = s1_c0_q;
         for (int m = 0; m < j; m++) begin
            acc = acc & s1_gp_q[m];
         end
         for (int k = 0; k < j; k++) begin
            term = s1_gg_q[k];
            for (int m = k + 1; m < j; m++) begin
               term = term & s1_gp_q[m];
            end
            acc = acc | term;
         end
         gc[j] = acc;
      end
      for (int j = 0; j < NG; j++) begin
         pv    = s1_p_q[4*j +: 4];
         gv    = s1_g_q[j];
         cv[0] = gc[j];
         cv[1] = gv[0] | (pv[0] & cv[0]);
         cv[2] = gv[1] | (pv[1] & cv[1]);
         cv[3] = gv[2] | (pv[2] & cv[2]);
         sum_res[4*j +: 4] = pv ^ cv;
`ifdef CLA_PIPE_FLAGS_EN
         if (j == NG - 1) begin
            msb_cin = cv[3];
         end
`endif
      end
   end

   // S2 next state: take the resolved result when S1 moves forward.
   always_comb begin
      sum_d  = sum_q;
      cout_d = cout_q;
`ifdef CLA_PIPE_FLAGS_EN
      zero_d = zero_q;
      ovf_d  = ovf_q;
`endif
      if (s2_load) begin
         sum_d  = sum_res;
         cout_d = gc[NG];
`ifdef CLA_PIPE_FLAGS_EN
         zero_d = (sum_res == '0);
         ovf_d  = msb_cin ^ gc[NG];
`endif
      end
   end

   // Pipeline registers; reset empties both stages and clears all data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         out_valid_q <= 1'b0;
         s1_p_q      <= '0;
         s1_g_q      <= '0;
         s1_gp_q     <= '0;
         s1_gg_q     <= '0;
         s1_c0_q     <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
`ifdef CLA_PIPE_FLAGS_EN
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         s1_valid_q  <= s1_valid_d;
         out_valid_q <= out_valid_d;
         s1_p_q      <= s1_p_d;
         s1_g_q      <= s1_g_d;
         s1_gp_q     <= s1_gp_d;
         s1_gg_q     <= s1_gg_d;
         s1_c0_q     <= s1_c0_d;
         sum_q       <= sum_d;
         cout_q      <= cout_d;
`ifdef CLA_PIPE_FLAGS_EN
         zero_q      <= zero_d;
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
`ifdef CLA_PIPE_FLAGS_EN
   assign zero      = zero_q;
   assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (WIDTH=64). A behavioural model
// computes expected {ovf,zero,cout,sum} when a beat is accepted and the
// scoreboard queue is popped as results retire.
module tb_cla_pipe_adder;

   localparam int W = 64;

   typedef logic [W+2:0] exp_t;

`ifdef CLA_PIPE_FLAGS_EN
   localparam exp_t MASK = '1;
`else
   localparam exp_t MASK = {2'b00, {(W+1){1'b1}}};
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   exp_t         obs;
`ifdef CLA_PIPE_FLAGS_EN
   logic         zero;
   logic         ovf;
`endif

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   cla_pipe_adder #(.WIDTH(W), .GROUP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout)
`ifdef CLA_PIPE_FLAGS_EN
      ,
      .zero      (zero),
      .ovf       (ovf)
`endif
   );

`ifdef CLA_PIPE_FLAGS_EN
   always_comb obs = {ovf, zero, cout, sum};
`else
   always_comb obs = {2'b00, cout, sum};
`endif

   function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                  input logic ci, input logic sb_i);
      logic [W-1:0] be;
      logic [W:0]   r;
      logic         z;
      logic         o;
      be = sb_i ? ~bb : bb;
      r  = {1'b0, aa} + {1'b0, be} + {{W{1'b0}}, (sb_i ? 1'b1 : ci)};
      z  = (r[W-1:0] == '0);
      o  = (aa[W-1] == be[W-1]) && (r[W-1] != aa[W-1]);
      return {o, z, r};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_vec++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h want 0", sum); end
      n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b want 0", cout); end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
`ifdef CLA_PIPE_FLAGS_EN
      n_vec++; if ({zero, ovf} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {zero, ovf}); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_basic_add();
      exp_t e;
      @(negedge clk);
      a = 64'h0000_0000_FFFF_FFFF; b = 64'd1; cin = 1'b0; sub = 1'b0;
      out_ready = 1'b1; in_valid = 1'b1; #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_in_ready: got %b want 1", in_ready); end
      sb.push_back(model(a, b, cin, sub));
      @(negedge clk); in_valid = 1'b0; #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL add_latency_early: got %b want 0", out_valid); end
      @(negedge clk); #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL add_latency: got %b want 1", out_valid); end
      n_vec++; if (sum !== 64'h0000_0001_0000_0000) begin n_err++; $display("FAIL add_sum: got %h want 0000000100000000", sum); end
      n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL add_cout: got %b want 0", cout); end
      e = sb.pop_front();
      n_vec++; if ((obs & MASK) !== (e & MASK)) begin n_err++; $display("FAIL add_model: got %h want %h", obs & MASK, e & MASK); end
   endtask

   task automatic test_full_carry();
      @(negedge clk);
      a = '1; b = '0; cin = 1'b1; sub = 1'b0; out_ready = 1'b1; in_valid = 1'b1; #1;
      sb.push_back(model(a, b, cin, sub));
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL carry_valid: got %b want 1", out_valid); end
      n_vec++; if (sum !== '0) begin n_err++; $display("FAIL carry_sum: got %h want 0", sum); end
      n_vec++; if (cout !== 1'b1) begin n_err++; $display("FAIL carry_cout: got %b want 1", cout); end
`ifdef CLA_PIPE_FLAGS_EN
      n_vec++; if ({zero, ovf} !== 2'b10) begin n_err++; $display("FAIL carry_flags: got %b want 10", {zero, ovf}); end
`endif
      void'(sb.pop_front());
   endtask

   task automatic test_subtract();
      exp_t e;
      @(negedge clk);
      a = 64'd5; b = 64'd7; cin = 1'b1; sub = 1'b1; out_ready = 1'b1; in_valid = 1'b1; #1;
      sb.push_back(model(a, b, cin, sub));
      @(negedge clk);
      a = 64'd7; b = 64'd5; cin = 1'b0; sub = 1'b1; #1;
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL sub_b2b_ready: got %b want 1", in_ready); end
      sb.push_back(model(a, b, cin, sub));
      @(negedge clk); in_valid = 1'b0; #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sub1_valid: got %b want 1", out_valid); end
      n_vec++; if (sum !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL sub1_sum: got %h want fffffffffffffffe", sum); end
      n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL sub1_cout: got %b want 0", cout); end
      e = sb.pop_front();
      n_vec++; if ((obs & MASK) !== (e & MASK)) begin n_err++; $display("FAIL sub1_model: got %h want %h", obs & MASK, e & MASK); end
      @(negedge clk); #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sub2_valid: got %b want 1", out_valid); end
      n_vec++; if (sum !== 64'd2) begin n_err++; $display("FAIL sub2_sum: got %h want 2", sum); end
      n_vec++; if (cout !== 1'b1) begin n_err++; $display("FAIL sub2_cout: got %b want 1", cout); end
      e = sb.pop_front();
      n_vec++; if ((obs & MASK) !== (e & MASK)) begin n_err++; $display("FAIL sub2_model: got %h want %h", obs & MASK, e & MASK); end
      @(negedge clk); #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL sub_no_dup: got %b want 0", out_valid); end
   endtask

`ifdef CLA_PIPE_FLAGS_EN
   task automatic test_flags();
      @(negedge clk);
      a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'd1; cin = 1'b0; sub = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
      @(negedge clk); in_valid = 1'b0;
      @(negedge clk); #1;
      n_vec++; if (sum !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL ovf_sum: got %h want 8000000000000000", sum); end
      n_vec++; if ({zero, ovf} !== 2'b01) begin n_err++; $display("FAIL ovf_flags: got %b want 01", {zero, ovf}); end
   endtask
`endif

   task automatic test_backpressure();
      int   acc_n = 0;
      int   ret_n = 0;
      exp_t e;
      for (int cyc = 0; cyc < 20 && ret_n < 4; cyc++) begin
         @(negedge clk);
         out_ready = (cyc >= 3);
         in_valid  = (acc_n < 4);
         a = W'(acc_n + 1); b = W'(acc_n + 1); cin = 1'b0; sub = 1'b0;
         #1;
         if (cyc == 2 || cyc == 3) begin
            n_vec++; if (out_valid !== 1'b1 || sum !== 64'd2) begin n_err++; $display("FAIL bp_hold_c%0d: got valid=%b sum=%h want valid=1 sum=2", cyc, out_valid, sum); end
         end
         if (cyc == 2) begin
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
            n_vec++; if (acc_n !== 2) begin n_err++; $display("FAIL bp_accepted: got %0d want 2", acc_n); end
         end
         if (cyc >= 4 && cyc <= 6) begin
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_stream_c%0d: got %b want 1", cyc, out_valid); end
         end
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL bp_extra: got sum=%h want no beat", sum);
            end else begin
               e = sb.pop_front();
               if ((obs & MASK) !== (e & MASK) || sum !== W'(2 * (ret_n + 1))) begin
                  n_err++; $display("FAIL bp_order%0d: got %h want %h", ret_n, sum, W'(2 * (ret_n + 1)));
               end
            end
            ret_n++;
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(a, b, cin, sub));
            acc_n++;
         end
      end
      in_valid = 1'b0;
      n_vec++; if (ret_n !== 4) begin n_err++; $display("FAIL bp_count: got %0d want 4", ret_n); end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; a = 64'd10; b = 64'd20; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
      a = 64'd30; b = 64'd40;
      @(negedge clk); in_valid = 1'b0; #1;
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL arst_inflight: got %b want 1", out_valid); end
      #2 rst_n = 1'b0; #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", out_valid); end
      n_vec++; if (sum !== '0) begin n_err++; $display("FAIL arst_sum: got %h want 0", sum); end
      n_vec++; if (cout !== 1'b0) begin n_err++; $display("FAIL arst_cout: got %b want 0", cout); end
      sb.delete();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL arst_stale%0d: got %b want 0", i, out_valid); end
      end
   endtask

   task automatic test_random();
      int           acc_n = 0;
      int           cyc = 0;
      logic         stall_prev = 1'b0;
      logic [W-1:0] sum_prev = '0;
      logic         cout_prev = 1'b0;
      exp_t         e;
      while ((acc_n < 10000 || sb.size() != 0) && cyc < 60000) begin
         @(negedge clk);
         in_valid  = (acc_n < 10000) && ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       a = '1;
            1:       a = '0;
            2:       a = 64'h7FFF_FFFF_FFFF_FFFF;
            default: a = {$urandom, $urandom};
         endcase
         case ($urandom_range(0, 7))
            0:       b = '1;
            1:       b = '0;
            2:       b = 64'd1;
            default: b = {$urandom, $urandom};
         endcase
         cin = 1'($urandom_range(0, 1));
         sub = 1'($urandom_range(0, 1));
         #1;
         if (stall_prev) begin
            n_vec++;
            if (out_valid !== 1'b1 || sum !== sum_prev || cout !== cout_prev) begin
               n_err++; $display("FAIL rnd_hold: got v=%b s=%h c=%b want v=1 s=%h c=%b", out_valid, sum, cout, sum_prev, cout_prev);
            end
         end
         if (out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
               n_err++; $display("FAIL rnd_extra: got sum=%h want no beat", sum);
            end else begin
               e = sb.pop_front();
               if ((obs & MASK) !== (e & MASK)) begin
                  n_err++; $display("FAIL rnd_result: got %h want %h", obs & MASK, e & MASK);
               end
            end
         end
         if (in_valid && in_ready) begin
            sb.push_back(model(a, b, cin, sub));
            acc_n++;
         end
         stall_prev = out_valid && !out_ready;
         sum_prev   = sum;
         cout_prev  = cout;
         cyc++;
      end
      in_valid = 1'b0;
      n_vec++; if (cyc >= 60000) begin n_err++; $display("FAIL rnd_timeout: got %0d pending want 0", sb.size()); end
      n_vec++; if (acc_n !== 10000) begin n_err++; $display("FAIL rnd_accepted: got %0d want 10000", acc_n); end
   endtask

   initial begin
      test_reset();
      test_basic_add();
      test_full_carry();
      test_subtract();
`ifdef CLA_PIPE_FLAGS_EN
      test_flags();
`endif
      test_backpressure();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
